pc_sequencer: RTL and testbench

//   Next-generation program counter for the CPU fetch stage. Holds the fetch PC and selects the next PC

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-PC control bundle between the decode/control unit and the PC sequencer.
// Latency: none, this is wiring only; the sequencer registers every output.
// Backpressure: none on this bundle; stall is the only hold request.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic [2:0]        pc_control;
  logic [25:0]       jmp_addr;
  logic [15:0]       branch_offset;
  logic [ADDR_W-1:0] reg_addr;
  logic              exc_req;
  logic              eret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc;
  logic              addr_err;
  logic              ras_hit;

  // Control side: drives redirect requests and observes the fetch PC.
  modport master (
    output stall, pc_control, jmp_addr, branch_offset, reg_addr, exc_req, eret,
    input  pc, epc, addr_err, ras_hit
  );

  // Sequencer side.
  modport slave (
    input  stall, pc_control, jmp_addr, branch_offset, reg_addr, exc_req, eret,
    output pc, epc, addr_err, ras_hit
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter: picks the next PC (seq/jump/reg/branch/call/return/exception/eret).
// Latency: every redirect appears on pc one cycle after the sampling edge; outputs are registered.
// Backpressure: stall holds pc, epc, state and RAS; exc_req and eret override it.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.slave     bus
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  // Illegal configurations show up as a named marker scope in the elaborated hierarchy.
  if (ADDR_W < 28 || ADDR_W > 64) begin : g_illegal_addr_w
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_illegal_ras_depth
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              addr_err_q, addr_err_d;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] br_tgt;
  logic              reg_misaligned;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];
  logic [PW-1:0]     ras_top_q, ras_top_d;
  logic [PW:0]       ras_cnt_q, ras_cnt_d;
  logic              ras_hit_q;
  logic              do_push;
  logic              do_pop;
`endif

  // Candidate targets, all relative to the current fetch PC.
  always_comb begin
    seq_pc         = pc_q + ADDR_W'(4);
    // Jump keeps the upper bits of the sequential PC and replaces the low 28.
    jmp_tgt        = seq_pc;
    jmp_tgt[27:0]  = {bus.jmp_addr, 2'b00};
    br_tgt         = seq_pc + {{(ADDR_W-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    reg_misaligned = (bus.reg_addr[1:0] != 2'b00);
  end

  // Next-state and next-PC selection, in priority order exc_req > eret > stall > control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_err_d = 1'b0;
`ifdef PC_RAS_EN
    do_push    = 1'b0;
    do_pop     = 1'b0;
`endif
    if (bus.exc_req) begin
      epc_d   = pc_q;
      pc_d    = EXC_VEC;
      state_d = ST_FLUSH;
    end else if (bus.eret) begin
      pc_d    = epc_q;
      state_d = ST_RUN;
    end else if (bus.stall) begin
      // Everything holds.
    end else if (state_q == ST_FLUSH) begin
      // One sequential slot after exception entry; control is ignored.
      pc_d    = seq_pc;
      state_d = ST_RUN;
    end else begin
      unique case (bus.pc_control)
        3'b001: pc_d = jmp_tgt;
        3'b011: pc_d = br_tgt;
        3'b100: begin
          pc_d = jmp_tgt;
`ifdef PC_RAS_EN
          do_push = 1'b1;
`endif
        end
        3'b010, 3'b101: begin
`ifdef PC_RAS_EN
          // A return with a live RAS entry ignores reg_addr entirely.
          if (bus.pc_control[2] && ras_cnt_q != '0) begin
            pc_d   = ras_mem_q[ras_top_q];
            do_pop = 1'b1;
          end else
`endif
          if (reg_misaligned) begin
            // Misaligned register target is taken as an exception.
            epc_d      = pc_q;
            pc_d       = EXC_VEC;
            addr_err_d = 1'b1;
            state_d    = ST_FLUSH;
          end else begin
            pc_d = bus.reg_addr;
          end
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

  // Core state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef PC_RAS_EN
  // Circular return stack: push past full overwrites the oldest entry, count saturates.
  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    if (do_push) begin
      ras_top_d            = ras_top_q + 1'b1;
      ras_mem_d[ras_top_d] = seq_pc;
      if (ras_cnt_q != (PW+1)'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + 1'b1;
      end
    end else if (do_pop) begin
      ras_top_d = ras_top_q - 1'b1;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  // RAS registers; reset empties the stack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
      ras_top_q <= '0;
      ras_cnt_q <= '0;
      ras_hit_q <= 1'b0;
    end else begin
      ras_mem_q <= ras_mem_d;
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
      ras_hit_q <= do_pop;
    end
  end

  assign bus.ras_hit = ras_hit_q;
`else
  assign bus.ras_hit = 1'b0;
`endif

  assign bus.pc       = pc_q;
  assign bus.epc      = epc_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (ADDR_W=32, default vectors).
// Latency: inputs applied on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: stall sequences are part of the vector table.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W   (32),
    .RESET_VEC(32'h0000_0000),
    .EXC_VEC  (32'h0000_0180),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  ctl;
    logic [25:0] jmp;
    logic [15:0] off;
    logic [31:0] rega;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        err;
    logic        hit;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic r, input logic st, input logic [2:0] c, input logic [25:0] j,
                     input logic [15:0] o, input logic [31:0] ra, input logic e, input logic er,
                     input logic [31:0] p, input logic [31:0] ep, input logic ae, input logic h);
    vec_t v;
    v.rst = r; v.stall = st; v.ctl = c; v.jmp = j; v.off = o; v.rega = ra;
    v.exc = e; v.eret = er; v.pc = p; v.epc = ep; v.err = ae; v.hit = h;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst               = v.rst;
    bus.stall         = v.stall;
    bus.pc_control    = v.ctl;
    bus.jmp_addr      = v.jmp;
    bus.branch_offset = v.off;
    bus.reg_addr      = v.rega;
    bus.exc_req       = v.exc;
    bus.eret          = v.eret;
  endtask

  initial begin
    vec_t idle;
    idle = '{rst: 1'b1, stall: 1'b0, ctl: 3'b000, jmp: '0, off: '0, rega: '0,
             exc: 1'b0, eret: 1'b0, pc: '0, epc: '0, err: 1'b0, hit: 1'b0};
    drive(idle);
    rst = 1'b0;

    //   rst st ctl     jmp          off       reg           exc er  pc             epc         err hit
    add(0, 0, 3'd1, 26'h3FFFFFF, 16'h0,    32'h0,        0, 0, 32'h0,        32'h0,      0, 0); // reset
    add(0, 0, 3'd1, 26'h3FFFFFF, 16'h0,    32'h0,        0, 0, 32'h0,        32'h0,      0, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h4,        32'h0,      0, 0); // seq
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h8,        32'h0,      0, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'hC,        32'h0,      0, 0);
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h0,      0, 0); // reg
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h0,        32'h0,      0, 0); // wrap
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'h100,      0, 0, 32'h100,      32'h0,      0, 0);
    add(1, 0, 3'd3, 26'h0,       16'hFFFF, 32'h0,        0, 0, 32'h100,      32'h0,      0, 0); // branch -1
    add(1, 0, 3'd3, 26'h0,       16'h0004, 32'h0,        0, 0, 32'h114,      32'h0,      0, 0); // branch +4
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'h10000000, 0, 0, 32'h10000000, 32'h0,      0, 0);
    add(1, 0, 3'd1, 26'h10,      16'h0,    32'h0,        0, 0, 32'h10000040, 32'h0,      0, 0); // jump
    add(1, 1, 3'd1, 26'h0,       16'h0,    32'h0,        0, 0, 32'h10000040, 32'h0,      0, 0); // stall
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'h200,      0, 0, 32'h200,      32'h0,      0, 0);
    add(1, 1, 3'd1, 26'h0,       16'h0,    32'h0,        1, 0, 32'h180,      32'h200,    0, 0); // exc+stall
    add(1, 0, 3'd1, 26'h55,      16'h0,    32'h0,        0, 0, 32'h184,      32'h200,    0, 0); // flush
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 1, 32'h200,      32'h200,    0, 0); // eret
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'h302,      0, 0, 32'h180,      32'h200,    1, 0); // misalign
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h184,      32'h200,    0, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        1, 0, 32'h180,      32'h184,    0, 0); // exc
    add(1, 1, 3'd1, 26'h0,       16'h0,    32'h0,        0, 0, 32'h180,      32'h184,    0, 0); // stall in flush
    add(1, 0, 3'd1, 26'h40,      16'h0,    32'h0,        0, 0, 32'h184,      32'h184,    0, 0); // still flush
    add(1, 0, 3'd1, 26'h40,      16'h0,    32'h0,        0, 0, 32'h100,      32'h184,    0, 0); // run again
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        1, 0, 32'h180,      32'h100,    0, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        1, 0, 32'h180,      32'h180,    0, 0); // exc in flush
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h184,      32'h180,    0, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 1, 32'h180,      32'h180,    0, 0);
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'h240,      0, 0, 32'h240,      32'h180,    0, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        1, 1, 32'h180,      32'h240,    0, 0); // exc beats eret
    add(1, 1, 3'd0, 26'h0,       16'h0,    32'h0,        0, 1, 32'h240,      32'h240,    0, 0); // eret beats stall
    add(1, 0, 3'd1, 26'h20,      16'h0,    32'h0,        0, 0, 32'h80,       32'h240,    0, 0); // back in RUN
    add(0, 0, 3'd0, 26'h0,       16'h0,    32'h0,        1, 0, 32'h0,        32'h0,      0, 0); // reset beats exc
    add(1, 0, 3'd6, 26'h0,       16'h0,    32'h0,        0, 0, 32'h4,        32'h0,      0, 0); // 11x = seq
    add(1, 0, 3'd7, 26'h0,       16'h0,    32'h0,        0, 0, 32'h8,        32'h0,      0, 0);
    add(1, 0, 3'd2, 26'h0,       16'h0,    32'h301,      0, 0, 32'h180,      32'h8,      1, 0);
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h184,      32'h8,      0, 0);
    add(1, 0, 3'd5, 26'h0,       16'h0,    32'h303,      0, 0, 32'h180,      32'h184,    1, 0); // empty ret trap
    add(1, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h184,      32'h184,    0, 0);
    // Call/return sequence from a fresh reset.
    add(0, 0, 3'd0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h0,        32'h0,      0, 0);
    add(1, 0, 3'd4, 26'h4,       16'h0,    32'h0,        0, 0, 32'h10,       32'h0,      0, 0);
    add(1, 0, 3'd4, 26'h8,       16'h0,    32'h0,        0, 0, 32'h20,       32'h0,      0, 0);
    add(1, 0, 3'd4, 26'hC,       16'h0,    32'h0,        0, 0, 32'h30,       32'h0,      0, 0);
    add(1, 0, 3'd4, 26'h10,      16'h0,    32'h0,        0, 0, 32'h40,       32'h0,      0, 0);
    add(1, 0, 3'd4, 26'h400,     16'h0,    32'h0,        0, 0, 32'h1000,     32'h0,      0, 0);
`ifdef PC_RAS_EN
    add(1, 0, 3'd5, 26'h0,       16'h0,    32'h800,      0, 0, 32'h44,       32'h0,      0, 1);
    add(1, 0, 3'd5, 26'h0,       16'h0,    32'h800,      0, 0, 32'h34,       32'h0,      0, 1);
    add(1, 0, 3'd5, 26'h0,       16'h0,    32'h800,      0, 0, 32'h24,       32'h0,      0, 1);
    add(1, 0, 3'd5, 26'h0,       16'h0,    32'h800,      0, 0, 32'h14,       32'h0,      0, 1);
    add(1, 0, 3'd5, 26'h0,       16'h0,    32'h800,      0, 0, 32'h800,      32'h0,      0, 0);
`else
    for (int i = 0; i < 5; i++) begin
      add(1, 0, 3'd5, 26'h0,     16'h0,    32'h800,      0, 0, 32'h800,      32'h0,      0, 0);
    end
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk("pc",       i, bus.pc,               vecs[i].pc);
      chk("epc",      i, bus.epc,              vecs[i].epc);
      chk("addr_err", i, {31'b0, bus.addr_err}, {31'b0, vecs[i].err});
      chk("ras_hit",  i, {31'b0, bus.ras_hit},  {31'b0, vecs[i].hit});
    end

    // Long stall: pc must hold and pulses must stay low across several cycles.
    @(negedge clk);
    drive(idle);
    bus.stall      = 1'b1;
    bus.pc_control = 3'd1;
    bus.jmp_addr   = 26'h123;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_pc",  i, bus.pc,                32'h800);
      chk("stall_hit", i, {31'b0, bus.ras_hit},  32'h0);
    end
    // Releasing the stall resumes with the pending jump.
    @(negedge clk);
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    chk("release_pc", 0, bus.pc, 32'h48C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
